// File: rtl/shaper_peak_ctrl.sv
// Peak-capture event controller placed after the trapezoidal shaper; emits (peak, timestamp) events through a FWFT FIFO.
// Optional build macro SHAPER_PILEUP_FLAG_EN adds a FIFO-carried pile-up flag (o_evt_pileup).
module shaper_peak_ctrl #(
    parameter int SIZE_FILTER_DATA = 16,
    parameter int TS_WIDTH         = 32,
    parameter int FIFO_DEPTH       = 4,
    parameter int HOLDOFF_WIDTH    = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_enable,
    input  logic [SIZE_FILTER_DATA-1:0] i_threshold,
    input  logic [HOLDOFF_WIDTH-1:0]    i_holdoff_len,
    input  logic [SIZE_FILTER_DATA-1:0] i_filt_data,
    output logic                        o_evt_valid,
    input  logic                        i_evt_ready,
    output logic [SIZE_FILTER_DATA-1:0] o_evt_peak,
    output logic [TS_WIDTH-1:0]         o_evt_time,
    output logic [7:0]                  o_drop_cnt,
    output logic                        o_busy
`ifdef SHAPER_PILEUP_FLAG_EN
    ,
    output logic                        o_evt_pileup
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, RISE, HOLDOFF} state_t;

    state_t                      r_state;
    state_t                      w_nextState;
    logic [TS_WIDTH-1:0]         r_ts;
    logic [TS_WIDTH-1:0]         r_maxTime;
    logic [SIZE_FILTER_DATA-1:0] r_maxVal;
    logic [HOLDOFF_WIDTH-1:0]    r_holdCnt;
    logic [7:0]                  r_dropCnt;
    logic [PTR_W:0]              r_wrPtr;
    logic [PTR_W:0]              r_rdPtr;
    logic [SIZE_FILTER_DATA-1:0] r_memPeak [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]         r_memTime [FIFO_DEPTH];
    logic                        w_above;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_wrEn;
    logic                        w_drop;
    logic                        w_full;
    logic                        w_empty;

    assign w_above = i_filt_data > i_threshold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ts    <= '0;
        end else begin
            r_state <= w_nextState;
            r_ts    <= r_ts + TS_WIDTH'(1);
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_push      = 1'b0;
        if (!i_enable) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_nextState = ARMED;
                ARMED:   if (w_above) w_nextState = RISE;
                RISE: begin
                    if (i_filt_data < r_maxVal) begin
                        w_push      = 1'b1;
                        w_nextState = HOLDOFF;
                    end
                end
                HOLDOFF: if (r_holdCnt == '0 && !w_above) w_nextState = ARMED;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Equal samples in RISE keep the earliest timestamp of a flat top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_maxVal  <= '0;
            r_maxTime <= '0;
            r_holdCnt <= '0;
        end else begin
            if (i_enable && r_state == ARMED && w_above) begin
                r_maxVal  <= i_filt_data;
                r_maxTime <= r_ts;
            end else if (i_enable && r_state == RISE && i_filt_data > r_maxVal) begin
                r_maxVal  <= i_filt_data;
                r_maxTime <= r_ts;
            end
            if (!i_enable) begin
                r_holdCnt <= '0;
            end else if (w_push) begin
                r_holdCnt <= i_holdoff_len;
            end else if (r_state == HOLDOFF && r_holdCnt != '0) begin
                r_holdCnt <= r_holdCnt - HOLDOFF_WIDTH'(1);
            end
        end
    end

    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                     (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
    assign w_pop   = !w_empty && i_evt_ready;
    assign w_wrEn  = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_dropCnt <= '0;
        end else begin
            if (w_wrEn) r_wrPtr <= r_wrPtr + (PTR_W+1)'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + (PTR_W+1)'(1);
            if (w_drop && r_dropCnt != 8'hFF) r_dropCnt <= r_dropCnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_memPeak[r_wrPtr[PTR_W-1:0]] <= r_maxVal;
            r_memTime[r_wrPtr[PTR_W-1:0]] <= r_maxTime;
        end
    end

    assign o_evt_valid = !w_empty;
    assign o_evt_peak  = w_empty ? '0 : r_memPeak[r_rdPtr[PTR_W-1:0]];
    assign o_evt_time  = w_empty ? '0 : r_memTime[r_rdPtr[PTR_W-1:0]];
    assign o_drop_cnt  = r_dropCnt;
    assign o_busy      = (r_state == RISE) || (r_state == HOLDOFF);

`ifdef SHAPER_PILEUP_FLAG_EN
    logic r_seenBelow;
    logic r_pending;
    logic r_memPile [FIFO_DEPTH];

    // A dip then re-rise while still in HOLDOFF marks the next event as piled up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seenBelow <= 1'b0;
            r_pending   <= 1'b0;
        end else if (!i_enable) begin
            r_seenBelow <= 1'b0;
            r_pending   <= 1'b0;
        end else if (w_push) begin
            r_seenBelow <= 1'b0;
            r_pending   <= 1'b0;
        end else if (r_state == HOLDOFF) begin
            if (!w_above)         r_seenBelow <= 1'b1;
            else if (r_seenBelow) r_pending   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wrEn) r_memPile[r_wrPtr[PTR_W-1:0]] <= r_pending;
    end

    assign o_evt_pileup = w_empty ? 1'b0 : r_memPile[r_rdPtr[PTR_W-1:0]];
`endif

endmodule

// File: tb/tb_shaper_peak_ctrl.sv
// Directed bench for shaper_peak_ctrl: event-list model plus hand-computed pulse expectations.
// Pile-up checks compile only with SHAPER_PILEUP_FLAG_EN.
module tb_shaper_peak_ctrl;

    localparam int DW = 16;
    localparam int TW = 32;
    localparam int HW = 12;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          evtReady = 1'b0;
    logic [DW-1:0] threshold = 16'd100;
    logic [HW-1:0] holdoffLen = 12'd5;
    logic [DW-1:0] filtData = '0;
    logic          evtValid;
    logic [DW-1:0] evtPeak;
    logic [TW-1:0] evtTime;
    logic [7:0]    dropCnt;
    logic          busy;
`ifdef SHAPER_PILEUP_FLAG_EN
    logic          evtPileup;
`endif

    int vecCount = 0;
    int missCount = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    shaper_peak_ctrl #(
        .SIZE_FILTER_DATA(DW), .TS_WIDTH(TW), .FIFO_DEPTH(DEPTH), .HOLDOFF_WIDTH(HW)
    ) dut (
        .clk(clk), .reset(reset), .i_enable(enable), .i_threshold(threshold),
        .i_holdoff_len(holdoffLen), .i_filt_data(filtData), .o_evt_valid(evtValid),
        .i_evt_ready(evtReady), .o_evt_peak(evtPeak), .o_evt_time(evtTime),
        .o_drop_cnt(dropCnt), .o_busy(busy)
`ifdef SHAPER_PILEUP_FLAG_EN
        , .o_evt_pileup(evtPileup)
`endif
    );

    // Model: pulse phase, pending event list and drop tally derived from the detection rules.
    typedef struct { int unsigned peak; logic [TW-1:0] tstamp; bit pile; } evt_t;
    localparam int SLEEP = 0, WAIT = 1, TRACK = 2, DEAD = 3;
    evt_t          mQ[$];
    int            phase = SLEEP;
    int unsigned   mMax = 0;
    logic [TW-1:0] mMaxT = '0;
    logic [TW-1:0] mTs = '0;
    int            deadLeft = 0;
    int            mDrops = 0;
    bit            dipped = 1'b0;
    bit            pend = 1'b0;

    task automatic modelStep();
        bit   above;
        bit   popNow;
        bit   wasFull;
        bit   pushNow;
        evt_t item;
        above   = filtData > threshold;
        popNow  = (mQ.size() != 0) && evtReady;
        wasFull = (mQ.size() == DEPTH);
        pushNow = 1'b0;
        if (!enable) begin
            phase  = SLEEP;
            pend   = 1'b0;
            dipped = 1'b0;
        end else if (phase == SLEEP) begin
            phase = WAIT;
        end else if (phase == WAIT) begin
            if (above) begin
                phase = TRACK;
                mMax  = filtData;
                mMaxT = mTs;
            end
        end else if (phase == TRACK) begin
            if (filtData > mMax) begin
                mMax  = filtData;
                mMaxT = mTs;
            end else if (filtData < mMax) begin
                pushNow    = 1'b1;
                item.peak  = mMax;
                item.tstamp = mMaxT;
                item.pile  = pend;
                pend       = 1'b0;
                dipped     = 1'b0;
                deadLeft   = holdoffLen;
                phase      = DEAD;
            end
        end else begin
            if (!above) dipped = 1'b1;
            else if (dipped) pend = 1'b1;
            if (deadLeft > 0) deadLeft--;
            else if (!above) phase = WAIT;
        end
        if (popNow) void'(mQ.pop_front());
        if (pushNow) begin
            if (!wasFull || popNow) mQ.push_back(item);
            else if (mDrops < 255) mDrops++;
        end
        mTs = mTs + 1;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mQ.delete();
            phase = SLEEP; mMax = 0; mMaxT = '0; mTs = '0;
            deadLeft = 0; mDrops = 0; dipped = 1'b0; pend = 1'b0;
        end else begin
            modelStep();
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_valid", 64'(evtValid), 64'(mQ.size() != 0));
            if (mQ.size() != 0) begin
                checkOutput("model_peak", 64'(evtPeak), 64'(mQ[0].peak));
                checkOutput("model_time", 64'(evtTime), 64'(mQ[0].tstamp));
`ifdef SHAPER_PILEUP_FLAG_EN
                checkOutput("model_pileup", 64'(evtPileup), 64'(mQ[0].pile));
`endif
            end
            checkOutput("model_drop", 64'(dropCnt), 64'(mDrops));
            checkOutput("model_busy", 64'(busy), 64'(phase == TRACK || phase == DEAD));
        end
    end

    // One sample per call; the k-th call after doReset carries timestamp k.
    task automatic applyStimulus(input bit en, input int unsigned fd, input bit rdy);
        enable   = en;
        filtData = DW'(fd);
        evtReady = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        enable = 1'b0; filtData = '0; evtReady = 1'b0;
        reset = 1'b0;
        checkEn = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    int busyCount;
    int unsigned pulseA [12] = '{0, 50, 150, 300, 250, 0, 0, 0, 0, 0, 0, 0};
    int unsigned stallA [19] = '{0, 200, 300, 250, 250, 250, 250, 250, 250, 250, 250, 250, 250, 250, 0, 0, 0, 0, 0};

    initial begin
        #7;
        // Reset mid-pulse
        doReset();
        threshold = 16'd100; holdoffLen = 12'd5;
        applyStimulus(1, 0, 0);
        applyStimulus(1, 150, 0);
        applyStimulus(1, 200, 0);
        checkOutput("rst_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        checkOutput("rst_async_busy", 64'(busy), 64'd0);
        checkOutput("rst_async_valid", 64'(evtValid), 64'd0);
        checkOutput("rst_async_peak", 64'(evtPeak), 64'd0);
        checkOutput("rst_async_time", 64'(evtTime), 64'd0);
        checkOutput("rst_async_drop", 64'(dropCnt), 64'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0);
        checkOutput("rst_no_event", 64'(evtValid), 64'd0);

        // Single pulse
        doReset();
        threshold = 16'd100; holdoffLen = 12'd5;
        busyCount = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, pulseA[i], 0);
            busyCount += int'(busy);
            if (i == 3) checkOutput("pulse_valid_early", 64'(evtValid), 64'd0);
            if (i == 4) begin
                checkOutput("pulse_valid", 64'(evtValid), 64'd1);
                checkOutput("pulse_peak", 64'(evtPeak), 64'd300);
                checkOutput("pulse_time", 64'(evtTime), 64'd3);
            end
        end
        checkOutput("pulse_busy_cycles", 64'(busyCount), 64'd8);
        applyStimulus(1, 0, 1);
        checkOutput("pulse_popped", 64'(evtValid), 64'd0);

        // Flat top
        doReset();
        threshold = 16'd100; holdoffLen = 12'd1;
        applyStimulus(1, 0, 0);
        applyStimulus(1, 200, 0);
        applyStimulus(1, 200, 0);
        applyStimulus(1, 200, 0);
        applyStimulus(1, 150, 0);
        checkOutput("flat_peak", 64'(evtPeak), 64'd200);
        checkOutput("flat_time", 64'(evtTime), 64'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1);

        // Backpressure / overflow
        doReset();
        threshold = 16'd100; holdoffLen = 12'd0;
        applyStimulus(1, 0, 0);
        for (int p = 0; p < 6; p++) begin
            applyStimulus(1, 110 + 10 * p, 0);
            applyStimulus(1, 0, 0);
            applyStimulus(1, 0, 0);
        end
        checkOutput("ovf_drop", 64'(dropCnt), 64'd2);
        for (int p = 0; p < 4; p++) begin
            checkOutput("ovf_valid", 64'(evtValid), 64'd1);
            checkOutput("ovf_peak", 64'(evtPeak), 64'(110 + 10 * p));
            checkOutput("ovf_time", 64'(evtTime), 64'(1 + 3 * p));
            applyStimulus(1, 0, 1);
        end
        checkOutput("ovf_empty", 64'(evtValid), 64'd0);
        checkOutput("ovf_drop_kept", 64'(dropCnt), 64'd2);

        // Abort in RISE then re-enable
        doReset();
        threshold = 16'd100; holdoffLen = 12'd2;
        applyStimulus(1, 0, 0);
        applyStimulus(1, 150, 0);
        applyStimulus(1, 300, 0);
        applyStimulus(0, 300, 0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_valid", 64'(evtValid), 64'd0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 200, 0);
        applyStimulus(1, 500, 0);
        applyStimulus(1, 400, 0);
        checkOutput("abort_new_peak", 64'(evtPeak), 64'd500);
        checkOutput("abort_new_time", 64'(evtTime), 64'd6);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1);

        // Holdoff stall: signal stays above past the holdoff length
        doReset();
        threshold = 16'd100; holdoffLen = 12'd2;
        for (int i = 0; i < 14; i++) applyStimulus(1, stallA[i], 0);
        checkOutput("stall_busy", 64'(busy), 64'd1);
        checkOutput("stall_peak", 64'(evtPeak), 64'd300);
        checkOutput("stall_time", 64'(evtTime), 64'd2);
        applyStimulus(1, 250, 1);
        checkOutput("stall_one_event", 64'(evtValid), 64'd0);
        for (int i = 14; i < 19; i++) applyStimulus(1, stallA[i], 0);
        checkOutput("stall_rearmed", 64'(busy), 64'd0);

`ifdef SHAPER_PILEUP_FLAG_EN
        // Dip and re-rise inside holdoff flags the following event
        doReset();
        threshold = 16'd100; holdoffLen = 12'd6;
        applyStimulus(1, 0, 0);
        applyStimulus(1, 200, 0);
        applyStimulus(1, 300, 0);
        applyStimulus(1, 250, 0);
        applyStimulus(1, 50, 0);
        applyStimulus(1, 200, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 50, 0);
        applyStimulus(1, 220, 0);
        applyStimulus(1, 50, 0);
        checkOutput("pile_first_flag", 64'(evtPileup), 64'd0);
        checkOutput("pile_first_peak", 64'(evtPeak), 64'd300);
        applyStimulus(1, 50, 1);
        checkOutput("pile_second_peak", 64'(evtPeak), 64'd220);
        checkOutput("pile_second_time", 64'(evtTime), 64'd11);
        checkOutput("pile_second_flag", 64'(evtPileup), 64'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/shaper_peak_ctrl.md
Name: shaper_peak_ctrl

Overview:
Event controller that sits after the trapezoidal shaping filter. It watches the filtered stream and sequences peak capture: arm, threshold crossing, maximum tracking, event emission and holdoff. Each detected pulse produces one (peak amplitude, timestamp) event, buffered in a small FIFO and handed downstream over a valid/ready handshake to the readout logic.

Parameters:
SIZE_FILTER_DATA, 16, width of the filter output and of peak/threshold values (unsigned)
TS_WIDTH, 32, width of the free-running sample timestamp
FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)
HOLDOFF_WIDTH, 12, width of the holdoff length field

Ports:
clk  in  1  clock, one filter sample per cycle
reset  in  1  asynchronous, active-low
enable  in  1  1 = detection running; 0 = forced IDLE
threshold  in  SIZE_FILTER_DATA  trigger level, sampled every cycle
holdoff_len  in  HOLDOFF_WIDTH  dead time in cycles after each peak
filt_data  in  SIZE_FILTER_DATA  filter output sample
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  downstream accepts head when evt_valid=1
evt_peak  out  SIZE_FILTER_DATA  peak amplitude of head event
evt_time  out  TS_WIDTH  timestamp of the peak sample of head event
drop_cnt  out  8  events lost to FIFO full, saturating at 255
busy  out  1  1 when state is not IDLE or ARMED

Behaviour:
- Reset (reset=0, async): state=IDLE, timestamp=0, FIFO empty, evt_valid=0, evt_peak=0, evt_time=0, drop_cnt=0, busy=0, holdoff counter=0.
- Timestamp: increments every cycle after reset; wraps 2^TS_WIDTH-1 -> 0 without any flag.
- All comparisons are unsigned; "above" means filt_data > threshold (strict).
- States: IDLE, ARMED, RISE, HOLDOFF.
- IDLE: enable=1 -> ARMED next cycle.
- ARMED: filt_data above -> RISE; load max=filt_data and max_time=timestamp.
- RISE: filt_data > max -> update max and max_time; equal keeps the first time. filt_data < max -> peak found: push {max, max_time} and go to HOLDOFF with counter=holdoff_len.
- HOLDOFF: counter decrements to 0. When counter==0 and filt_data not above, go to ARMED. When counter==0 and filt_data still above, stay in HOLDOFF; no new trigger until the signal drops.
- holdoff_len=0: HOLDOFF lasts exactly one cycle if the signal is below threshold.
- enable=0 in any state: IDLE next cycle. A pulse in RISE is aborted with no event. FIFO contents and drop_cnt are kept.
- Push latency: event is written on the clock edge of the first sample below max. evt_valid rises the next cycle if the FIFO was empty.
- FIFO is first-word-fall-through: evt_peak/evt_time show the head while evt_valid=1. Pop on evt_valid & evt_ready.
- Push while full: event dropped, drop_cnt+1 (saturating); FIFO unchanged. Push and pop in the same cycle while full: both happen, no drop.
- Outputs are stable while evt_valid=1 and evt_ready=0.
- threshold or holdoff_len change: takes effect on the next comparison or load; no retiming.

Optional Feature:
SHAPER_PILEUP_FLAG_EN:
- Defined: adds output evt_pileup (1 bit, FIFO-carried, reset 0). While in HOLDOFF, if filt_data goes not-above and then above again before HOLDOFF exits, a pending flag is set. The next pushed event carries evt_pileup=1 and the pending flag clears on that push. enable=0 also clears pending.
- Undefined: port absent, no pending logic.

Test Plan:
- Reset mid-pulse: assert reset=0 while in RISE -> outputs go to reset values immediately (async); no event appears after release.
- Single pulse: threshold=100, holdoff_len=5, filt_data 0,50,150,300,250,0 -> one event evt_peak=300 with evt_time = timestamp of the 300 sample; evt_valid one cycle after the 250 sample; busy=1 for RISE plus 6 HOLDOFF cycles.
- Flat top: samples 200,200,200,150 with threshold=100 -> evt_peak=200, evt_time = first 200 sample.
- Backpressure/overflow: FIFO_DEPTH=4, evt_ready=0, 6 pulses -> 4 events stored in order, drop_cnt=2; then evt_ready=1 -> 4 pops in order, evt_valid=0 afterwards.
- Abort: enable dropped in RISE -> no event, state IDLE; re-enable with a new pulse peaking at 500 -> event with evt_peak=500.
- Holdoff stall: holdoff_len=2, signal stays above threshold 10 cycles past the peak -> exactly one event; re-arm only after filt_data <= threshold. With SHAPER_PILEUP_FLAG_EN: a dip below threshold and re-rise inside holdoff -> next event has evt_pileup=1.
